cpu_ctrl: RTL
=============

CPU_CTRL -- requirements
Module: cpu_ctrl

Interface
REQ-001 Parameter: RESET_PC, 5'd0, program counter value loaded on reset.
REQ-002 Port: tclk  input  1  system clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset; asynchronous, active-high.
REQ-004 Port: a_bus  output  5  memory address bus.
REQ-005 Port: d_bus  inout  8  shared data bus; driven by cpu_ctrl only while dbusSelect=1, else 8'bz.
REQ-006 Port: dbusSelect  output  1  bus direction; 0 = memory drives d_bus, 1 = cpu_ctrl drives d_bus.
REQ-007 Port: instruction  output  8  instruction presented to memory; memory writes d_bus to mem[a_bus], or to its output register when a_bus=31, at the rising edge while instruction[7:5]=3'b100.
REQ-008 Port: acc_out  output  8  accumulator value.
REQ-009 Port: pc_out  output  5  program counter value.
REQ-010 Port: halted  output  1  high while in HALT; constant 0 when CPU_CTRL_HALT_EN is undefined.

Function
REQ-011 Instruction format: [7:5] opcode, [4:0] operand address.
REQ-012 Opcodes: 000 ADD (ACC<=ACC+M, mod 256, carry discarded); 010 NAND (ACC<=~(ACC&M)); 101 LD (ACC<=M); 100 ST (M<=ACC); 111 JPNZ (PC<=operand if ACC!=0); 001, 011 and 110 are NOP unless REQ-025 applies.
REQ-013 FSM states: FETCH_A, FETCH_B, EXEC_A, EXEC_B, HALT; every instruction takes exactly 4 cycles, FETCH_A->FETCH_B->EXEC_A->EXEC_B->FETCH_A.
REQ-014 FETCH_A: a_bus=PC, dbusSelect=0, instruction=8'h00.
REQ-015 FETCH_B: a_bus=PC, dbusSelect=0, instruction=8'h00; at exit edge IR<=d_bus and PC<=PC+1, wrapping 31->0.
REQ-016 EXEC_A: a_bus=IR[4:0]; for ST, dbusSelect=1, d_bus=ACC and instruction=IR, giving exactly one memory write at the exit edge; for all other opcodes, dbusSelect=0 and instruction=8'h00.
REQ-017 EXEC_B: a_bus=IR[4:0], dbusSelect=0, instruction=8'h00; at exit edge ADD/NAND/LD update ACC from d_bus, and JPNZ loads PC when ACC!=0.
REQ-018 instruction[7:5] shall equal 3'b100 only in EXEC_A of an ST, so no spurious write can occur during fetch.
REQ-019 JPNZ overrides the FETCH_B increment; with ACC=0 execution continues at the already-incremented PC.
REQ-020 Operand address 30 (input port) and 31 (output port) are treated as ordinary addresses; no special casing in cpu_ctrl.
REQ-021 dbusSelect=1 and a driven d_bus shall never coexist with memory driving the bus; dbusSelect changes only on state transitions.

Reset
REQ-022 While rst is high: state=FETCH_A, PC=RESET_PC, ACC=8'h00, IR=8'h00, dbusSelect=0, instruction=8'h00, halted=0, d_bus=8'bz.
REQ-023 rst asserted mid-instruction, including EXEC_A of an ST, aborts immediately; the interrupted instruction has no further effect after deassertion.
REQ-024 First fetch occurs in the first cycle after rst deasserts.

Configuration
REQ-025 Macro CPU_CTRL_HALT_EN defined: opcode 110 moves EXEC_B->HALT; HALT holds PC and ACC, keeps dbusSelect=0 and instruction=8'h00, sets halted=1, and is left only via rst.
REQ-026 Macro CPU_CTRL_HALT_EN undefined: opcode 110 is NOP, the HALT state is absent, and halted is tied to 0.

Structure
REQ-027 Shared package cpu_pkg holds the opcode constants (OP_ADD, OP_NAND, OP_LD, OP_ST, OP_JPNZ, OP_HALT) and the FSM state enum typedef.
REQ-028 One sub-module, cpu_alu, is combinational: inputs ACC, M and opcode; output is the result for ADD, NAND and LD.

Verification
REQ-029 Reset: assert rst mid-EXEC_A -> next cycle PC=0, ACC=0, dbusSelect=0, instruction=8'h00, with no memory write.
REQ-030 With the team mem block holding the ROM program at 0-4 and inp=8'h5A: after 8 cycles ACC=8'h5A and oup=8'h5A; after 16 cycles PC=0 (NAND gives 8'hFF, so JPNZ is taken).
REQ-031 ADD overflow: ACC=8'hF0 and M=8'h20 -> ACC=8'h10.
REQ-032 JPNZ not taken: ACC=0 and IR=8'hE7 at PC=9 -> next fetch address is 10.
REQ-033 PC wrap: NOP at address 31 -> next fetch a_bus=0.
REQ-034 HALT (CPU_CTRL_HALT_EN defined): IR=8'hC0 -> halted=1 four cycles after fetch, PC frozen for 100 cycles; with the macro undefined the same opcode acts as NOP.

Source files
------------

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module  : cpu_pkg
// Brief   : Opcode constants and FSM state encoding shared by cpu_ctrl.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_LD   = 3'b101;
    localparam logic [2:0] OP_ST   = 3'b100;
    localparam logic [2:0] OP_JPNZ = 3'b111;
    localparam logic [2:0] OP_HALT = 3'b110;

    typedef enum logic [2:0] {
        FETCH_A = 3'd0,
        FETCH_B = 3'd1,
        EXEC_A  = 3'd2,
        EXEC_B  = 3'd3,
        HALT    = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/cpu_alu.sv
// ============================================================================
// Module  : cpu_alu
// Brief   : Combinational accumulator datapath for ADD, NAND and LD.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module cpu_alu
    import cpu_pkg::*;
(
    input  logic [7:0] i_acc,
    input  logic [7:0] i_mem,
    input  logic [2:0] i_op,
    output logic [7:0] o_result
);

    always_comb begin
        o_result = i_acc;
        case (i_op)
            OP_ADD:  o_result = i_acc + i_mem;
            OP_NAND: o_result = ~(i_acc & i_mem);
            OP_LD:   o_result = i_mem;
            default: o_result = i_acc;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/cpu_ctrl.sv
// ============================================================================
// Module  : cpu_ctrl
// Brief   : Four-cycle accumulator CPU controller driving a shared memory bus.
//           Define CPU_CTRL_HALT_EN to make opcode 110 enter a sticky HALT.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module cpu_ctrl
    import cpu_pkg::*;
#(
    parameter logic [4:0] RESET_PC = 5'd0
) (
    input  logic       tclk,
    input  logic       rst,
    output logic [4:0] a_bus,
    inout  wire  [7:0] d_bus,
    output logic       dbusSelect,
    output logic [7:0] instruction,
    output logic [7:0] acc_out,
    output logic [4:0] pc_out,
    output logic       halted
);

    state_t     r_state;
    logic [4:0] r_pc;
    logic [7:0] r_acc;
    logic [7:0] r_ir;
    logic [4:0] r_a_bus;
    logic       r_dbus_sel;
    logic [7:0] r_instr;

    logic [2:0] w_op;
    logic [7:0] w_alu_res;
    logic       w_alu_op;
    logic       w_jump;
    logic [4:0] w_next_pc;
    logic       w_halt_op;

    assign w_op      = r_ir[7:5];
    assign w_alu_op  = (w_op == OP_ADD) || (w_op == OP_NAND) || (w_op == OP_LD);
    assign w_jump    = (w_op == OP_JPNZ) && (r_acc != 8'h00);
    assign w_next_pc = w_jump ? r_ir[4:0] : r_pc;

`ifdef CPU_CTRL_HALT_EN
    logic r_halted;
    assign w_halt_op = (w_op == OP_HALT);
    assign halted    = r_halted;
`else
    assign w_halt_op = 1'b0;
    assign halted    = 1'b0;
`endif

    cpu_alu u_alu (
        .i_acc    (r_acc),
        .i_mem    (d_bus),
        .i_op     (w_op),
        .o_result (w_alu_res)
    );

    // Bus outputs are registered for the state being entered, so they only move on transitions.
    always_ff @(posedge tclk or posedge rst) begin
        if (rst) begin
            r_state    <= FETCH_A;
            r_pc       <= RESET_PC;
            r_acc      <= 8'h00;
            r_ir       <= 8'h00;
            r_a_bus    <= RESET_PC;
            r_dbus_sel <= 1'b0;
            r_instr    <= 8'h00;
`ifdef CPU_CTRL_HALT_EN
            r_halted   <= 1'b0;
`endif
        end else begin
            case (r_state)
                FETCH_A: begin
                    r_state <= FETCH_B;
                end
                FETCH_B: begin
                    r_state <= EXEC_A;
                    r_ir    <= d_bus;
                    r_pc    <= r_pc + 5'd1;
                    r_a_bus <= d_bus[4:0];
                    if (d_bus[7:5] == OP_ST) begin
                        r_dbus_sel <= 1'b1;
                        r_instr    <= d_bus;
                    end
                end
                EXEC_A: begin
                    r_state    <= EXEC_B;
                    r_dbus_sel <= 1'b0;
                    r_instr    <= 8'h00;
                end
                EXEC_B: begin
                    if (w_alu_op) begin
                        r_acc <= w_alu_res;
                    end
                    r_pc <= w_next_pc;
                    if (w_halt_op) begin
                        r_state  <= HALT;
`ifdef CPU_CTRL_HALT_EN
                        r_halted <= 1'b1;
`endif
                    end else begin
                        r_state <= FETCH_A;
                        r_a_bus <= w_next_pc;
                    end
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

    assign d_bus       = r_dbus_sel ? r_acc : 8'bz;
    assign a_bus       = r_a_bus;
    assign dbusSelect  = r_dbus_sel;
    assign instruction = r_instr;
    assign acc_out     = r_acc;
    assign pc_out      = r_pc;

endmodule

`default_nettype wire
